// File: rtl/dmux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream_router
// Purpose  : Registered 1-to-N stream router with unicast, broadcast and a
//            one-entry valid/ready holding slot per output channel.
// Revision : 1.0
// ============================================================================
module dmux_stream_router #(
    parameter int WIDTH    = 16,
    parameter int N        = 4,
    parameter int BCAST_EN = 1,
    localparam int SEL_W   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [7:0]           drop_cnt
);

    localparam logic [7:0] c_drop_max = 8'hFF;

    logic [N-1:0]       valid_q, valid_d;
    logic [N*WIDTH-1:0] data_q, data_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic [N-1:0]       w_free;
    logic [N-1:0]       w_sel_hit;
    logic [N-1:0]       w_load;
    logic               w_bcast;
    logic               w_oor;
    logic               w_in_ready;

    always_comb begin
        w_bcast = (BCAST_EN != 0) && in_bcast;
        w_free  = ~valid_q | out_ready;

        w_sel_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_sel_hit[i] = 1'b1;
            end
        end
        // A select that matches no channel can only occur for non-power-of-two N.
        w_oor = !w_bcast && !(|w_sel_hit);

        if (w_bcast) begin
            w_in_ready = &w_free;
        end else begin
            w_in_ready = w_oor || (|(w_sel_hit & w_free));
        end

        w_load = '0;
        if (in_valid && w_in_ready) begin
            w_load = w_bcast ? {N{1'b1}} : w_sel_hit;
        end

        valid_d = w_load | (valid_q & ~out_ready);
        data_d  = data_q;
        for (int i = 0; i < N; i++) begin
            if (w_load[i]) begin
                data_d[i*WIDTH +: WIDTH] = in_data;
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (in_valid && w_oor && (drop_cnt_q != c_drop_max)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_stream_router
// Purpose  : Directed vector bench for dmux_stream_router (N=4, N=4 without
//            broadcast, N=5 with out-of-range selects).
// Revision : 1.0
// ============================================================================
module tb_dmux_stream_router;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: N=4, broadcast enabled
    logic [15:0] a_data;
    logic [1:0]  a_sel;
    logic        a_bcast, a_valid, a_ready;
    logic [63:0] a_odata;
    logic [3:0]  a_ovalid, a_oready;
    logic [7:0]  a_drop;

    // Broadcast disabled instance
    logic [15:0] b_data;
    logic [1:0]  b_sel;
    logic        b_bcast, b_valid, b_ready;
    logic [63:0] b_odata;
    logic [3:0]  b_ovalid, b_oready;
    logic [7:0]  b_drop;

    // N=5 instance
    logic [15:0] c_data;
    logic [2:0]  c_sel;
    logic        c_bcast, c_valid, c_ready;
    logic [79:0] c_odata;
    logic [4:0]  c_ovalid, c_oready;
    logic [7:0]  c_drop;

    dmux_stream_router #(.WIDTH(16), .N(4), .BCAST_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel),
        .in_bcast(a_bcast), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
        .drop_cnt(a_drop)
    );

    dmux_stream_router #(.WIDTH(16), .N(4), .BCAST_EN(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
        .in_bcast(b_bcast), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
        .drop_cnt(b_drop)
    );

    dmux_stream_router #(.WIDTH(16), .N(5), .BCAST_EN(1)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel),
        .in_bcast(c_bcast), .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready),
        .drop_cnt(c_drop)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  sel;
        logic        bcast;
        logic        valid;
        logic [15:0] data;
        logic [3:0]  rdy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [63:0] exp_od;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int accepted;
        int exp_drop;

        // out_data order in expectations: {ch3, ch2, ch1, ch0}
        vecs[0]  = '{2'd0, 1'b0, 1'b1, 16'h1111, 4'b1111, 1'b1, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1111}};
        vecs[1]  = '{2'd1, 1'b0, 1'b1, 16'h2222, 4'b1111, 1'b1, 4'b0010, {16'h0000, 16'h0000, 16'h2222, 16'h1111}};
        vecs[2]  = '{2'd2, 1'b0, 1'b1, 16'h3333, 4'b1111, 1'b1, 4'b0100, {16'h0000, 16'h3333, 16'h2222, 16'h1111}};
        vecs[3]  = '{2'd3, 1'b0, 1'b1, 16'h4444, 4'b1111, 1'b1, 4'b1000, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vecs[4]  = '{2'd2, 1'b0, 1'b1, 16'hAAAA, 4'b1011, 1'b1, 4'b0100, {16'h4444, 16'hAAAA, 16'h2222, 16'h1111}};
        vecs[5]  = '{2'd2, 1'b0, 1'b1, 16'hBBBB, 4'b1011, 1'b0, 4'b0100, {16'h4444, 16'hAAAA, 16'h2222, 16'h1111}};
        vecs[6]  = '{2'd2, 1'b0, 1'b1, 16'hBBBB, 4'b1111, 1'b1, 4'b0100, {16'h4444, 16'hBBBB, 16'h2222, 16'h1111}};
        vecs[7]  = '{2'd1, 1'b0, 1'b1, 16'h0C01, 4'b1101, 1'b1, 4'b0010, {16'h4444, 16'hBBBB, 16'h0C01, 16'h1111}};
        vecs[8]  = '{2'd3, 1'b1, 1'b0, 16'h5A5A, 4'b1101, 1'b0, 4'b0010, {16'h4444, 16'hBBBB, 16'h0C01, 16'h1111}};
        vecs[9]  = '{2'd3, 1'b1, 1'b1, 16'h5A5A, 4'b1101, 1'b0, 4'b0010, {16'h4444, 16'hBBBB, 16'h0C01, 16'h1111}};
        vecs[10] = '{2'd3, 1'b1, 1'b1, 16'h5A5A, 4'b1111, 1'b1, 4'b1111, {16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A}};
        vecs[11] = '{2'd0, 1'b0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, {16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A}};
        vecs[12] = '{2'd3, 1'b0, 1'b1, 16'h0D03, 4'b0111, 1'b1, 4'b1000, {16'h0D03, 16'h5A5A, 16'h5A5A, 16'h5A5A}};
        vecs[13] = '{2'd1, 1'b1, 1'b1, 16'h1234, 4'b0111, 1'b0, 4'b1000, {16'h0D03, 16'h5A5A, 16'h5A5A, 16'h5A5A}};
        vecs[14] = '{2'd0, 1'b0, 1'b1, 16'h0E00, 4'b0111, 1'b1, 4'b1001, {16'h0D03, 16'h5A5A, 16'h5A5A, 16'h0E00}};
        vecs[15] = '{2'd3, 1'b0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, {16'h0D03, 16'h5A5A, 16'h5A5A, 16'h0E00}};

        a_data = '0; a_sel = '0; a_bcast = 1'b0; a_valid = 1'b0; a_oready = '1;
        b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_oready = '1;
        c_data = '0; c_sel = '0; c_bcast = 1'b0; c_valid = 1'b0; c_oready = '1;

        // Reset state
        #12;
        chk("reset_ovalid", 80'(a_ovalid), 80'd0);
        chk("reset_odata", 80'(a_odata), 80'd0);
        chk("reset_drop", 80'(a_drop), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: unicast, backpressure, broadcast stall, independence of in_valid
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_sel = vecs[i].sel; a_bcast = vecs[i].bcast; a_valid = vecs[i].valid;
            a_data = vecs[i].data; a_oready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 80'(a_ready), 80'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 80'(a_ovalid), 80'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_data", i), 80'(a_odata), 80'(vecs[i].exp_od));
        end
        @(negedge clk);
        a_valid = 1'b0; a_bcast = 1'b0; a_oready = '1;

        // Broadcast disabled: bcast request becomes unicast to in_sel
        b_sel = 2'd2; b_bcast = 1'b1; b_valid = 1'b1; b_data = 16'h5A5A;
        #1;
        chk("nob_in_ready", 80'(b_ready), 80'd1);
        @(posedge clk);
        #1;
        chk("nob_out_valid", 80'(b_ovalid), 80'b0100);
        chk("nob_out_data", 80'(b_odata), 80'({16'h0000, 16'h5A5A, 16'h0000, 16'h0000}));
        @(negedge clk);
        b_valid = 1'b0; b_bcast = 1'b0;

        // N=5: valid unicast to the top channel
        c_sel = 3'd4; c_valid = 1'b1; c_data = 16'h4545;
        #1;
        chk("n5_uni_in_ready", 80'(c_ready), 80'd1);
        @(posedge clk);
        #1;
        chk("n5_uni_out_valid", 80'(c_ovalid), 80'b10000);
        chk("n5_uni_out_data", c_odata, {16'h4545, 64'd0});

        // N=5: out-of-range drops, saturating counter
        exp_drop = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            c_sel = 3'd6; c_valid = 1'b1; c_data = 16'(k);
            #1;
            chk($sformatf("oor%0d_in_ready", k), 80'(c_ready), 80'd1);
            @(posedge clk);
            #1;
            if (exp_drop < 255) exp_drop++;
            chk($sformatf("oor%0d_out_valid", k), 80'(c_ovalid), 80'd0);
            chk($sformatf("oor%0d_drop_cnt", k), 80'(c_drop), 80'(exp_drop));
        end
        @(negedge clk);
        c_valid = 1'b0;
        chk("oor_final_drop", 80'(c_drop), 80'd255);

        // Independence: ch0 stalled with a word, stream 8 words to ch3
        a_sel = 2'd0; a_valid = 1'b1; a_data = 16'h00C0; a_oready = 4'b1110;
        @(posedge clk);
        #1;
        chk("ind_ch0_load", 80'(a_ovalid), 80'b0001);
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a_sel = 2'd3; a_valid = 1'b1; a_data = 16'h3000 + 16'(k);
            #1;
            chk($sformatf("ind%0d_in_ready", k), 80'(a_ready), 80'd1);
            if (a_ready) accepted++;
            @(posedge clk);
            #1;
            chk($sformatf("ind%0d_out_valid", k), 80'(a_ovalid), 80'b1001);
            chk($sformatf("ind%0d_ch3", k), 80'(a_odata[63:48]), 80'(16'h3000 + 16'(k)));
            chk($sformatf("ind%0d_ch0", k), 80'(a_odata[15:0]), 80'(16'h00C0));
        end
        chk("ind_accepted", 80'(accepted), 80'd8);

        // Asynchronous reset mid-cycle with slots loaded
        @(negedge clk);
        a_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_ovalid", 80'(a_ovalid), 80'd0);
        chk("areset_odata", 80'(a_odata), 80'd0);
        chk("areset_nob_ovalid", 80'(b_ovalid), 80'd0);
        chk("areset_n5_drop", 80'(c_drop), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_sel = 2'd0; a_oready = 4'b0000;
        #1;
        chk("post_reset_in_ready", 80'(a_ready), 80'd1);
        chk("post_reset_ovalid", 80'(a_ovalid), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
